// File: rtl/dc_mmu_responder.sv
// -----------------------------------------------------------------------------
// dc_mmu_responder
//
// MMU-side responder for the data cache. It services three kinds of request
// from the dcache and turns each one into 32-bit beats on one external bus:
//   - dirty-line write-back followed by a line fill (dc_evict together with dc_miss)
//   - a clean line fill (dc_miss alone)
//   - a single uncached IO read or write (io_access)
// Fill data, IO read data and one-cycle ack pulses go back to the dcache.
//
// Ports
//   clk, rst        system clock; synchronous active-high reset
//   dc_miss*        line-fill request, fill line address
//   dc_evict*       write-back request, victim address and victim line data
//   dc_data_fill    assembled fill line, valid while dc_miss_ack is high
//   dc_miss_ack     one-cycle completion pulse for a fill (and its write-back)
//   io_*            uncached request (rw, address, write data)
//   io_rd_data      IO read data, valid while io_ack is high
//   io_ack          one-cycle completion pulse for an IO access
//   bus_*           beat request/handshake toward the memory/IO bus controller
// -----------------------------------------------------------------------------
module dc_mmu_responder #(
  parameter int LINE_W = 128,
  parameter int BUS_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dc_miss,
  input  logic [31:0]       dc_miss_addr,
  input  logic              dc_evict,
  input  logic [31:0]       dc_evict_addr,
  input  logic [LINE_W-1:0] dc_evict_data,
  output logic [LINE_W-1:0] dc_data_fill,
  output logic              dc_miss_ack,
  input  logic              io_access,
  input  logic              io_rw,
  input  logic [31:0]       io_addr,
  input  logic [31:0]       io_wr_data,
  output logic [31:0]       io_rd_data,
  output logic              io_ack,
  output logic              bus_req,
  output logic              bus_we,
  output logic              bus_io,
  output logic [31:0]       bus_addr,
  output logic [BUS_W-1:0]  bus_wdata,
  input  logic [BUS_W-1:0]  bus_rdata,
  input  logic              bus_ack
);

  localparam int BEATS = LINE_W / BUS_W;
  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [2:0] {
    IDLE,
    EVICT,
    FILL,
    IO,
    DONE
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    beat_cnt;
  logic [31:0]         miss_addr_q;
  logic [31:0]         evict_addr_q;
  logic [LINE_W-1:0]   evict_data_q;
  logic [31:0]         io_addr_q;
  logic [BUS_W-1:0]    io_wr_data_q;
  logic                io_rw_q;
  logic                last_beat;
  logic                beat_done;
  logic [31:0]         beat_offset;

  assign last_beat   = (beat_cnt == CNT_W'(BEATS - 1));
  // An ack only counts while a beat is actually being requested.
  assign beat_done   = bus_req && bus_ack;
  assign beat_offset = 32'(beat_cnt) << $clog2(BUS_W / 8);

  // Main controller. Requests are latched on leaving IDLE so the dcache inputs
  // may change freely afterwards. bus_req is raised one cycle after a beat
  // state is entered and is kept high across the EVICT->FILL hand-over so the
  // eight beats of a dirty miss run back to back. Ack pulses default low and
  // are raised for the single DONE cycle that follows the final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      bus_req      <= 1'b0;
      dc_miss_ack  <= 1'b0;
      io_ack       <= 1'b0;
      dc_data_fill <= '0;
      io_rd_data   <= '0;
      miss_addr_q  <= '0;
      evict_addr_q <= '0;
      evict_data_q <= '0;
      io_addr_q    <= '0;
      io_wr_data_q <= '0;
      io_rw_q      <= 1'b0;
    end else begin
      dc_miss_ack <= 1'b0;
      io_ack      <= 1'b0;
      case (state)
        IDLE: begin
          bus_req  <= 1'b0;
          beat_cnt <= '0;
          if (io_access) begin
            io_addr_q    <= io_addr;
            io_wr_data_q <= BUS_W'(io_wr_data);
            io_rw_q      <= io_rw;
            state        <= IO;
          end else if (dc_miss) begin
            miss_addr_q  <= dc_miss_addr;
            evict_addr_q <= dc_evict_addr;
            evict_data_q <= dc_evict_data;
            state        <= dc_evict ? EVICT : FILL;
          end
        end
        EVICT: begin
          if (!bus_req) begin
            bus_req <= 1'b1;
          end else if (beat_done) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= FILL;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        FILL: begin
          if (!bus_req) begin
            bus_req <= 1'b1;
          end else if (beat_done) begin
            dc_data_fill[beat_cnt*BUS_W +: BUS_W] <= bus_rdata;
            if (last_beat) begin
              beat_cnt    <= '0;
              bus_req     <= 1'b0;
              dc_miss_ack <= 1'b1;
              state       <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        IO: begin
          if (!bus_req) begin
            bus_req <= 1'b1;
          end else if (beat_done) begin
            if (!io_rw_q) begin
              io_rd_data <= 32'(bus_rdata);
            end
            bus_req <= 1'b0;
            io_ack  <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          // DONE: one quiet cycle so the dcache can drop its request.
          bus_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Beat attributes are decoded from registered state only, so they are held
  // steady for the whole time bus_req is high and read as zero when idle.
  always_comb begin
    bus_we    = 1'b0;
    bus_io    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state)
      EVICT: begin
        bus_we    = 1'b1;
        bus_addr  = evict_addr_q + beat_offset;
        bus_wdata = evict_data_q[beat_cnt*BUS_W +: BUS_W];
      end
      FILL: begin
        bus_addr = miss_addr_q + beat_offset;
      end
      IO: begin
        bus_io    = 1'b1;
        bus_we    = io_rw_q;
        bus_addr  = io_addr_q;
        bus_wdata = io_wr_data_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_dc_mmu_responder.sv
// -----------------------------------------------------------------------------
// tb_dc_mmu_responder
//
// Self-checking bench for dc_mmu_responder. A behavioural bus responder with a
// configurable number of wait states serves beats from a small sparse memory
// and records every accepted beat. For each request the bench derives the
// expected beat list, completion latency, fill line and IO read data from the
// request itself, then compares against what the design produced.
// -----------------------------------------------------------------------------
module tb_dc_mmu_responder;

  logic          clk = 1'b0;
  logic          rst;
  logic          dc_miss;
  logic [31:0]   dc_miss_addr;
  logic          dc_evict;
  logic [31:0]   dc_evict_addr;
  logic [127:0]  dc_evict_data;
  logic [127:0]  dc_data_fill;
  logic          dc_miss_ack;
  logic          io_access;
  logic          io_rw;
  logic [31:0]   io_addr;
  logic [31:0]   io_wr_data;
  logic [31:0]   io_rd_data;
  logic          io_ack;
  logic          bus_req;
  logic          bus_we;
  logic          bus_io;
  logic [31:0]   bus_addr;
  logic [31:0]   bus_wdata;
  logic [31:0]   bus_rdata;
  logic          bus_ack;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic        io;
    logic [31:0] wdata;
  } beat_t;

  beat_t         seenQ[$];
  beat_t         expQ[$];
  logic [31:0]   mem [logic [31:0]];
  int            waitStates = 0;
  int            waitCnt = 0;
  bit            spurious = 1'b0;
  int            missAcks = 0;
  int            ioAcks = 0;
  int            checks = 0;
  int            failures = 0;
  logic [127:0]  expFill = '0;
  logic [31:0]   expIoRd = '0;

  dc_mmu_responder dut (
    .clk           (clk),
    .rst           (rst),
    .dc_miss       (dc_miss),
    .dc_miss_addr  (dc_miss_addr),
    .dc_evict      (dc_evict),
    .dc_evict_addr (dc_evict_addr),
    .dc_evict_data (dc_evict_data),
    .dc_data_fill  (dc_data_fill),
    .dc_miss_ack   (dc_miss_ack),
    .io_access     (io_access),
    .io_rw         (io_rw),
    .io_addr       (io_addr),
    .io_wr_data    (io_wr_data),
    .io_rd_data    (io_rd_data),
    .io_ack        (io_ack),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_io        (bus_io),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_ack       (bus_ack)
  );

  always #5 clk = ~clk;

  // Sparse memory: preloaded words win, anything else is a fixed hash.
  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a ^ 32'h5A5A_C3C3) + 32'h1234_5678;
  endfunction

  // Bus responder: acks after waitStates idle cycles of an outstanding
  // request and logs the accepted beat. With spurious set it also pulses
  // ack while no request is pending.
  always @(negedge clk) begin
    if (bus_req) begin
      if (waitCnt >= waitStates) begin
        bus_ack   = 1'b1;
        bus_rdata = memRead(bus_addr);
        seenQ.push_back('{bus_addr, bus_we, bus_io, bus_wdata});
        waitCnt   = 0;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
        waitCnt++;
      end
    end else begin
      bus_ack   = spurious;
      bus_rdata = $urandom;
      waitCnt   = 0;
    end
  end

  // Count ack pulses seen by the dcache.
  always @(negedge clk) begin
    if (dc_miss_ack) missAcks++;
    if (io_ack) ioAcks++;
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Wait (bounded) for the chosen ack; cycles counts negedges after the
  // sampling posedge, i.e. the cycle number in which the ack is visible.
  task automatic waitAck(input bit wantIo, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(wantIo ? io_ack : dc_miss_ack) && cycles < 400);
  endtask

  task automatic checkBeats(input string tag);
    checkOutput({tag, "_beat_count"}, 128'(seenQ.size()), 128'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < seenQ.size(); i++) begin
      checkOutput($sformatf("%s_addr%0d", tag, i), 128'(seenQ[i].addr), 128'(expQ[i].addr));
      checkOutput($sformatf("%s_kind%0d", tag, i), {seenQ[i].we, seenQ[i].io},
                  {expQ[i].we, expQ[i].io});
      if (expQ[i].we)
        checkOutput($sformatf("%s_wdata%0d", tag, i), 128'(seenQ[i].wdata),
                    128'(expQ[i].wdata));
    end
  endtask

  // One complete request. kind: 0 clean miss, 1 dirty miss, 2 IO access.
  // Entered and left at a negedge with the responder idle.
  task automatic applyStimulus(input string tag, input int kind,
                               input logic [31:0] mAddr, input logic [31:0] eAddr,
                               input logic [127:0] eData, input logic rw,
                               input logic [31:0] iAddr, input logic [31:0] iWd,
                               input int waits);
    int cycles;
    int nBeats;
    waitStates = waits;
    seenQ.delete();
    expQ.delete();
    if (kind == 1)
      for (int i = 0; i < 4; i++)
        expQ.push_back('{eAddr + 32'(4*i), 1'b1, 1'b0, eData[32*i +: 32]});
    if (kind <= 1)
      for (int i = 0; i < 4; i++) begin
        expQ.push_back('{mAddr + 32'(4*i), 1'b0, 1'b0, 32'h0});
        expFill[32*i +: 32] = memRead(mAddr + 32'(4*i));
      end
    if (kind == 2) begin
      expQ.push_back('{iAddr, rw, 1'b1, iWd});
      if (!rw) expIoRd = memRead(iAddr);
    end
    nBeats = expQ.size();

    io_access     = (kind == 2);
    io_rw         = rw;
    io_addr       = iAddr;
    io_wr_data    = iWd;
    dc_miss       = (kind <= 1);
    dc_evict      = (kind == 1);
    dc_miss_addr  = mAddr;
    dc_evict_addr = eAddr;
    dc_evict_data = eData;
    @(posedge clk);
    waitAck(kind == 2, cycles);
    checkOutput({tag, "_latency"}, 128'(cycles), 128'(2 + nBeats * (waits + 1)));
    if (kind == 2) checkOutput({tag, "_io_rd_data"}, 128'(io_rd_data), 128'(expIoRd));
    else checkOutput({tag, "_fill"}, dc_data_fill, expFill);
    io_access = 1'b0;
    dc_miss   = 1'b0;
    dc_evict  = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_ack_pulse"}, {126'b0, dc_miss_ack, io_ack}, 128'b0);
    checkOutput({tag, "_bus_idle"}, 128'(bus_req), 128'b0);
    checkBeats(tag);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int cycles;
    int missBase;
    int ioBase;
    logic [127:0] rdata128;

    rst = 1'b1;
    dc_miss = 1'b0; dc_miss_addr = '0; dc_evict = 1'b0; dc_evict_addr = '0;
    dc_evict_data = '0; io_access = 1'b0; io_rw = 1'b0; io_addr = '0; io_wr_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_bus", {bus_req, bus_we, bus_io, bus_addr, bus_wdata}, '0);
    checkOutput("reset_acks", {dc_miss_ack, io_ack}, '0);
    checkOutput("reset_fill", dc_data_fill, '0);
    checkOutput("reset_io_rd", 128'(io_rd_data), '0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] clean miss at 0x120");
    mem[32'h120] = 32'h11; mem[32'h124] = 32'h22;
    mem[32'h128] = 32'h33; mem[32'h12C] = 32'h44;
    applyStimulus("clean", 0, 32'h120, 32'h0, '0, 1'b0, 32'h0, 32'h0, 0);
    checkOutput("clean_fill_const", dc_data_fill,
                128'h00000044_00000033_00000022_00000011);

    $display("[TB] dirty miss evict 0xA40 fill 0x40");
    applyStimulus("dirty", 1, 32'h40, 32'hA40,
                  128'hCAFE0003_BEEF0002_F00D0001_ABCD0000, 1'b0, 32'h0, 32'h0, 0);

    $display("[TB] IO read 0xF004 with 3 wait states");
    mem[32'hF004] = 32'hDEADBEEF;
    applyStimulus("io_read", 2, 32'h0, 32'h0, '0, 1'b0, 32'hF004, 32'h0, 3);
    checkOutput("io_read_const", 128'(io_rd_data), 128'hDEADBEEF);

    $display("[TB] IO write leaves read data alone");
    applyStimulus("io_write", 2, 32'h0, 32'h0, '0, 1'b1, 32'hF008, 32'h0BAD_F00D, 1);
    checkOutput("io_write_keeps_rd", 128'(io_rd_data), 128'hDEADBEEF);

    $display("[TB] simultaneous IO and miss");
    waitStates = 0;
    seenQ.delete();
    expQ.delete();
    missBase = missAcks;
    ioBase = ioAcks;
    expQ.push_back('{32'h3000, 1'b0, 1'b1, 32'h0});
    for (int i = 0; i < 4; i++) begin
      expQ.push_back('{32'h500 + 32'(4*i), 1'b0, 1'b0, 32'h0});
      expFill[32*i +: 32] = memRead(32'h500 + 32'(4*i));
    end
    expIoRd = memRead(32'h3000);
    io_access = 1'b1; io_rw = 1'b0; io_addr = 32'h3000;
    dc_miss = 1'b1; dc_miss_addr = 32'h500;
    @(posedge clk);
    waitAck(1'b1, cycles);
    checkOutput("prio_io_latency", 128'(cycles), 128'd3);
    checkOutput("prio_io_rd", 128'(io_rd_data), 128'(expIoRd));
    io_access = 1'b0;
    waitAck(1'b0, cycles);
    checkOutput("prio_fill", dc_data_fill, expFill);
    dc_miss = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("prio_io_ack_count", 128'(ioAcks - ioBase), 128'd1);
    checkOutput("prio_miss_ack_count", 128'(missAcks - missBase), 128'd1);
    checkBeats("prio");

    $display("[TB] reset during fill beat 2");
    missBase = missAcks;
    dc_miss = 1'b1; dc_miss_addr = 32'h7700;
    @(posedge clk);
    repeat (4) @(negedge clk);
    checkOutput("rst_mid_busy", 128'(bus_req), 128'd1);
    rst = 1'b1;
    dc_miss = 1'b0;
    @(negedge clk);
    checkOutput("rst_mid_bus_req", 128'(bus_req), 128'd0);
    checkOutput("rst_mid_fill", dc_data_fill, '0);
    checkOutput("rst_mid_io_rd", 128'(io_rd_data), '0);
    checkOutput("rst_mid_no_ack", 128'(missAcks - missBase), 128'd0);
    rst = 1'b0;
    expIoRd = '0;
    expFill = '0;
    applyStimulus("rst_reissue", 0, 32'h7700, 32'h0, '0, 1'b0, 32'h0, 32'h0, 0);

    $display("[TB] spurious ack and lone evict");
    missBase = missAcks;
    ioBase = ioAcks;
    seenQ.delete();
    spurious = 1'b1;
    dc_evict = 1'b1; dc_evict_addr = 32'hBB00; dc_evict_data = {4{32'h5555AAAA}};
    repeat (6) @(negedge clk);
    checkOutput("spur_bus_req", 128'(bus_req), 128'd0);
    checkOutput("spur_no_beats", 128'(seenQ.size()), 128'd0);
    checkOutput("spur_no_acks", 128'((missAcks - missBase) + (ioAcks - ioBase)), 128'd0);
    spurious = 1'b0;
    dc_evict = 1'b0;
    @(negedge clk);
    applyStimulus("post_spur", 0, 32'h2230, 32'h0, '0, 1'b0, 32'h0, 32'h0, 0);

    $display("[TB] randomized requests");
    for (int n = 0; n < 12; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      rdata128 = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus($sformatf("rand%0d", n), kind,
                    $urandom & 32'hFFFF_FFF0, $urandom & 32'hFFFF_FFF0, rdata128,
                    1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
                    $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
